core_reg_file_mp: RTL and testbench

// - Parametrised multi-port integer register file for the RISC-V core; successor to the 2R1W core register block.
// - Configurable XLEN, register count, read ports and write ports; entry 0 hardwired to zero.
// - Same-cycle write->read bypass.
// - Hardware init walker zeroes every entry after reset; the array itself has no reset.
// - Sits between decode (reads) and writeback (writes); init_busy stalls the core until the walk completes.

---
 rtl/core_reg_file_mp_pkg.sv | 15 +
 rtl/core_reg_file_mp_if.sv | 55 +++++
 rtl/core_reg_file_mp_rd_port.sv | 81 ++++++++
 rtl/core_reg_file_mp.sv | 133 +++++++++++++
 tb/tb_core_reg_file_mp.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_reg_file_mp_pkg.sv
// Shared types and helpers for the multi-port integer register file.
//   core_reg_state_e : init-walker state (INIT while zeroing, READY after)
//   addr_w()         : address width for a given entry count
//   REG_ZERO         : the value architecturally read from x0 / during init
package core_reg_pkg;

    typedef enum logic {INIT, READY} core_reg_state_e;

    function automatic int addr_w(int n);
        return $clog2(n);
    endfunction

    localparam logic [31:0] REG_ZERO = '0;

endpackage

// File: rtl/core_reg_file_mp_if.sv
// Bus between the core (decode/writeback, master side) and the register
// file (slave side).
//   stall_n    : master -> slave, 0 freezes the array (no commit, no bypass)
//   rd_addr    : master -> slave, one address per read port
//   rd_data    : slave -> master, combinational read data
//   wr_addr/wr_data/wr_en : master -> slave, one set per write port
//   init_busy  : slave -> master, 1 while the init walk runs
//   err_inject / par_err : only with CORE_REG_PARITY_EN defined
//
// Handshake: a write on port w is accepted at a rising edge exactly when
// wr_en[w]=1, stall_n=1 and init_busy=0 (init_busy acts as an inverted
// ready shared by all ports); there is no back-pressure per port and no
// retry, a write presented while not accepted is simply dropped. Reads
// have no handshake and are valid in the same cycle as the address.
interface core_reg_file_mp_if
    import core_reg_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_RPORTS = 2,
    parameter int NUM_WPORTS = 1
);
    localparam int AW = addr_w(NUM_REGS);

    logic                             stall_n;
    logic [NUM_RPORTS-1:0][AW-1:0]    rd_addr;
    logic [NUM_RPORTS-1:0][XLEN-1:0]  rd_data;
    logic [NUM_WPORTS-1:0][AW-1:0]    wr_addr;
    logic [NUM_WPORTS-1:0][XLEN-1:0]  wr_data;
    logic [NUM_WPORTS-1:0]            wr_en;
    logic                             init_busy;
`ifdef CORE_REG_PARITY_EN
    logic [NUM_WPORTS-1:0]            err_inject;
    logic [NUM_RPORTS-1:0]            par_err;
`endif

    modport master (
        output stall_n, rd_addr, wr_addr, wr_data, wr_en,
`ifdef CORE_REG_PARITY_EN
        output err_inject,
        input  par_err,
`endif
        input  rd_data, init_busy
    );

    modport slave (
        input  stall_n, rd_addr, wr_addr, wr_data, wr_en,
`ifdef CORE_REG_PARITY_EN
        input  err_inject,
        output par_err,
`endif
        output rd_data, init_busy
    );

endinterface

// File: rtl/core_reg_file_mp_rd_port.sv
// One read port of the register file: zero / bypass / array priority mux,
// plus the sticky parity-error flag when CORE_REG_PARITY_EN is defined.
//   clk, rst     : only present with parity (the flag is the only state)
//   ready_i      : register file has finished its init walk
//   rd_addr_i    : this port's read address
//   commit_i     : per write port, "commits at the next edge"
//   wr_addr_i/wr_data_i : write-port address/data for the bypass compare
//   arr_data_i   : array word at rd_addr_i
//   arr_par_i    : stored parity bit at rd_addr_i (parity build)
//   par_err_o    : sticky parity error flag (parity build)
//   rd_data_o    : read data, combinational
module core_reg_rd_port
    import core_reg_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int NUM_WPORTS = 1
) (
`ifdef CORE_REG_PARITY_EN
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            arr_par_i,
    output logic                            par_err_o,
`endif
    input  logic                            ready_i,
    input  logic [AW-1:0]                   rd_addr_i,
    input  logic [NUM_WPORTS-1:0]           commit_i,
    input  logic [NUM_WPORTS-1:0][AW-1:0]   wr_addr_i,
    input  logic [NUM_WPORTS-1:0][XLEN-1:0] wr_data_i,
    input  logic [XLEN-1:0]                 arr_data_i,
    output logic [XLEN-1:0]                 rd_data_o
);

    logic            byp_hit;
    logic [XLEN-1:0] byp_data;

    // Ascending scan so the highest-numbered matching port is the one left
    // in byp_data, mirroring the commit priority in the array.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        for (int w = 0; w < NUM_WPORTS; w++) begin
            if (commit_i[w] && (wr_addr_i[w] == rd_addr_i)) begin
                byp_hit  = 1'b1;
                byp_data = wr_data_i[w];
            end
        end
    end

    always_comb begin
        rd_data_o = XLEN'(REG_ZERO);
        if (!ready_i || (rd_addr_i == '0)) begin
            rd_data_o = XLEN'(REG_ZERO);
        end else if (byp_hit) begin
            rd_data_o = byp_data;
        end else begin
            rd_data_o = arr_data_i;
        end
    end

`ifdef CORE_REG_PARITY_EN
    logic arr_sel;
    logic par_err_d, par_err_q;

    // Only words actually taken from the array are checked; x0 and
    // forwarded data never carry stored parity.
    assign arr_sel   = ready_i && (rd_addr_i != '0) && !byp_hit;
    assign par_err_d = par_err_q | (arr_sel & ((^arr_data_i) != arr_par_i));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign par_err_o = par_err_q;
`endif

endmodule

// File: rtl/core_reg_file_mp.sv
// Multi-port integer register file with x0 hardwired to zero, same-cycle
// write->read bypass and a hardware init walker that zeroes entries
// 1..NUM_REGS-1 after reset (the array itself has no reset).
// Optional feature macro: CORE_REG_PARITY_EN (per-entry even parity,
// err_inject / par_err on the bus).
//   clk         : core clock
//   rst         : asynchronous active-high reset, restarts the init walk
//   bus         : core_reg_file_mp_if slave (reads, writes, stall, init_busy)
//   dbg_state_o : current init-walker state
module core_reg_file_mp
    import core_reg_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_RPORTS = 2,
    parameter int NUM_WPORTS = 1
) (
    input  logic               clk,
    input  logic               rst,
    core_reg_file_mp_if.slave  bus,
    output core_reg_state_e    dbg_state_o
);

    localparam int AW = addr_w(NUM_REGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    core_reg_state_e state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            ready;
    logic [NUM_WPORTS-1:0] commit;

    logic [XLEN-1:0] mem_q    [NUM_REGS];
    logic [XLEN-1:0] arr_data [NUM_RPORTS];
    logic [XLEN-1:0] rd_data  [NUM_RPORTS];
`ifdef CORE_REG_PARITY_EN
    logic            par_q    [NUM_REGS];
    logic            arr_par  [NUM_RPORTS];
`endif

    // ---------------- init walker ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign ready         = (state_q == READY);
    assign bus.init_busy = !ready;
    assign dbg_state_o   = state_q;

    // ---------------- commit ----------------
    always_comb begin
        commit = '0;
        for (int w = 0; w < NUM_WPORTS; w++) begin
            commit[w] = ready && bus.stall_n && bus.wr_en[w] && (bus.wr_addr[w] != '0);
        end
    end

    // No reset on the array: the walker provides the zero contents. Later
    // ports overwrite earlier ones within the loop, so the highest port
    // wins an address collision.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem_q[cnt_q] <= XLEN'(REG_ZERO);
`ifdef CORE_REG_PARITY_EN
            par_q[cnt_q] <= 1'b0;
`endif
        end else begin
            for (int w = 0; w < NUM_WPORTS; w++) begin
                if (commit[w]) begin
                    mem_q[bus.wr_addr[w]] <= bus.wr_data[w];
`ifdef CORE_REG_PARITY_EN
                    par_q[bus.wr_addr[w]] <= (^bus.wr_data[w]) ^ bus.err_inject[w];
`endif
                end
            end
        end
    end

    // ---------------- read ports ----------------
    for (genvar r = 0; r < NUM_RPORTS; r++) begin : g_rd
        assign arr_data[r] = mem_q[bus.rd_addr[r]];
`ifdef CORE_REG_PARITY_EN
        assign arr_par[r]  = par_q[bus.rd_addr[r]];
`endif

        core_reg_rd_port #(
            .XLEN       (XLEN),
            .AW         (AW),
            .NUM_WPORTS (NUM_WPORTS)
        ) u_rd_port (
`ifdef CORE_REG_PARITY_EN
            .clk        (clk),
            .rst        (rst),
            .arr_par_i  (arr_par[r]),
            .par_err_o  (bus.par_err[r]),
`endif
            .ready_i    (ready),
            .rd_addr_i  (bus.rd_addr[r]),
            .commit_i   (commit),
            .wr_addr_i  (bus.wr_addr),
            .wr_data_i  (bus.wr_data),
            .arr_data_i (arr_data[r]),
            .rd_data_o  (rd_data[r])
        );

        assign bus.rd_data[r] = rd_data[r];
    end

endmodule

// File: tb/tb_core_reg_file_mp.sv
// Testbench for core_reg_file_mp (XLEN=32, NUM_REGS=32, 2 read ports,
// 2 write ports). Inputs change at the falling edge, outputs are sampled
// shortly afterwards, well away from the rising edge.
// Also covers the CORE_REG_PARITY_EN build when that macro is defined.
module tb_core_reg_file_mp;
    import core_reg_pkg::*;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRP  = 2;
    localparam int NWP  = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    core_reg_file_mp_if #(.XLEN(XLEN), .NUM_REGS(NREG), .NUM_RPORTS(NRP), .NUM_WPORTS(NWP)) bus ();
    core_reg_state_e dbg_state;

    core_reg_file_mp #(
        .XLEN       (XLEN),
        .NUM_REGS   (NREG),
        .NUM_RPORTS (NRP),
        .NUM_WPORTS (NWP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Architectural view: busy for NREG-1 cycles after reset, then x1..x31
    // hold whatever was last committed.
    logic [31:0] mem_m [NREG];
    logic        par_bad_m [NREG];
    logic [1:0]  err_m;
    int          busy_left;

    function automatic logic byp_m(input logic [4:0] a);
        logic hit = 1'b0;
        for (int w = 0; w < NWP; w++)
            if (bus.stall_n && bus.wr_en[w] && bus.wr_addr[w] == a) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic [31:0] read_m(input logic [4:0] a);
        logic [31:0] v;
        if (busy_left > 0 || a == 5'd0) return 32'd0;
        v = mem_m[a];
        for (int w = 0; w < NWP; w++)
            if (bus.stall_n && bus.wr_en[w] && bus.wr_addr[w] == a) v = bus.wr_data[w];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            mem_m[i] = 32'd0;
            par_bad_m[i] = 1'b0;
        end
        err_m = 2'b00;
        busy_left = NREG - 1;
    endtask

    task automatic model_commit();
        if (busy_left > 0) begin
            busy_left--;
        end else begin
            for (int r = 0; r < NRP; r++)
                if (bus.rd_addr[r] != 5'd0 && !byp_m(bus.rd_addr[r]) && par_bad_m[bus.rd_addr[r]])
                    err_m[r] = 1'b1;
            if (bus.stall_n)
                for (int w = 0; w < NWP; w++)
                    if (bus.wr_en[w] && bus.wr_addr[w] != 5'd0) begin
                        mem_m[bus.wr_addr[w]] = bus.wr_data[w];
`ifdef CORE_REG_PARITY_EN
                        par_bad_m[bus.wr_addr[w]] = bus.err_inject[w];
`endif
                    end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic st, input logic [1:0] we,
                         input logic [4:0] wa0, input logic [4:0] wa1,
                         input logic [31:0] wd0, input logic [31:0] wd1,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        bus.stall_n    = st;
        bus.wr_en      = we;
        bus.wr_addr[0] = wa0;
        bus.wr_addr[1] = wa1;
        bus.wr_data[0] = wd0;
        bus.wr_data[1] = wd1;
        bus.rd_addr[0] = ra0;
        bus.rd_addr[1] = ra1;
`ifdef CORE_REG_PARITY_EN
        bus.err_inject = 2'b00;
`endif
    endtask

    // Called at a falling edge with inputs driven; checks, advances the
    // model over the coming rising edge, returns at the next falling edge.
    task automatic run_cycle(input string tag, input logic use_exp,
                             input logic [31:0] e0, input logic [31:0] e1);
        #1;
        if (use_exp) begin
            chk({tag, " rd0"}, bus.rd_data[0], e0);
            chk({tag, " rd1"}, bus.rd_data[1], e1);
        end else begin
            chk({tag, " rd0"}, bus.rd_data[0], read_m(bus.rd_addr[0]));
            chk({tag, " rd1"}, bus.rd_data[1], read_m(bus.rd_addr[1]));
        end
        chk({tag, " busy"}, 32'(bus.init_busy), 32'(busy_left > 0));
        chk({tag, " state"}, 32'(dbg_state), (busy_left > 0) ? 32'(INIT) : 32'(READY));
`ifdef CORE_REG_PARITY_EN
        chk({tag, " par_err"}, 32'(bus.par_err), 32'(err_m));
`endif
        model_commit();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd17);
        #1;
        chk("reset busy", 32'(bus.init_busy), 32'd1);
        chk("reset state", 32'(dbg_state), 32'(INIT));
        chk("reset rd0", bus.rd_data[0], 32'd0);
        chk("reset rd1", bus.rd_data[1], 32'd0);
`ifdef CORE_REG_PARITY_EN
        chk("reset par_err", 32'(bus.par_err), 32'd0);
`endif
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs the walk with a write to x5 attempted throughout, checks every
    // read is 0 and that init_busy stays high for exactly NREG-1 cycles.
    task automatic walk_and_count();
        int  cnt = 0;
        logic done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (busy_left > 0)
                drive(1'b1, 2'b01, 5'd5, 5'd0, 32'hFFFF_FFFF, 32'd0,
                      5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)));
            else
                drive(1'b1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd1);
            #1;
            if (bus.init_busy) cnt++;
            else done = 1'b1;
            run_cycle("walk", 1'b0, 32'd0, 32'd0);
        end
        chk("busy_len", 32'(cnt), 32'(NREG - 1));
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        st;
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [4:0]  ra0, ra1;
        logic [31:0] e0, e1;
    } vec_t;

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{1'b1, 2'b01, 5'd3, 5'd0, 32'hDEAD_BEEF, 32'd0, 5'd3, 5'd5, 32'hDEAD_BEEF, 32'd0};
        vecs[1]  = '{1'b1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 2'b01, 5'd0, 5'd0, 32'h1234, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0};
        vecs[3]  = '{1'b1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd3, 32'd0, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b1, 2'b01, 5'd7, 5'd0, 32'h1111_1111, 32'd0, 5'd7, 5'd7, 32'h1111_1111, 32'h1111_1111};
        vecs[5]  = '{1'b0, 2'b01, 5'd7, 5'd0, 32'h55, 32'd0, 5'd7, 5'd0, 32'h1111_1111, 32'd0};
        vecs[6]  = '{1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd7, 5'd7, 32'h1111_1111, 32'h1111_1111};
        vecs[7]  = '{1'b1, 2'b01, 5'd7, 5'd0, 32'h55, 32'd0, 5'd7, 5'd3, 32'h55, 32'hDEAD_BEEF};
        vecs[8]  = '{1'b1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd7, 5'd9, 32'h55, 32'd0};
        vecs[9]  = '{1'b1, 2'b11, 5'd9, 5'd9, 32'hA, 32'hB, 5'd9, 5'd9, 32'hB, 32'hB};
        vecs[10] = '{1'b1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd9, 5'd0, 32'hB, 32'd0};
        vecs[11] = '{1'b1, 2'b10, 5'd0, 5'd6, 32'd0, 32'h66, 5'd6, 5'd1, 32'h66, 32'd0};
        vecs[12] = '{1'b1, 2'b11, 5'd8, 5'd0, 32'h88, 32'h99, 5'd8, 5'd0, 32'h88, 32'd0};
        vecs[13] = '{1'b1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd8, 5'd6, 32'h88, 32'h66};
    end

    // ---------------- main sequence ----------------
    initial begin
        drive(1'b1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        model_reset();
        @(negedge clk);

        // Reset, partial walk, reset again: the walk must restart from 1.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            run_cycle("prewalk", 1'b0, 32'd0, 32'd0);
        end
        do_reset();
        walk_and_count();

        // Directed vectors.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].st, vecs[i].we, vecs[i].wa0, vecs[i].wa1,
                  vecs[i].wd0, vecs[i].wd1, vecs[i].ra0, vecs[i].ra1);
            run_cycle($sformatf("vec%0d", i), 1'b1, vecs[i].e0, vecs[i].e1);
        end

`ifdef CORE_REG_PARITY_EN
        // Corrupted parity on x4: bypass read is clean, array read flags
        // one cycle later and the flag stays.
        drive(1'b1, 2'b01, 5'd4, 5'd0, 32'h0F0F, 32'd0, 5'd4, 5'd0);
        bus.err_inject = 2'b01;
        run_cycle("par wr", 1'b1, 32'h0F0F, 32'd0);
        drive(1'b1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd4, 5'd0);
        #1;
        chk("par rd no flag yet", 32'(bus.par_err), 32'd0);
        run_cycle("par rd", 1'b1, 32'h0F0F, 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
            #1;
            chk("par sticky", 32'(bus.par_err), 32'd1);
            run_cycle("par hold", 1'b1, 32'd0, 32'd0);
        end
`endif

        // Randomized traffic against the model, addresses folded to a
        // small range so collisions and bypasses are frequent.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom, $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            run_cycle("rand", 1'b0, 32'd0, 32'd0);
        end

        // Reset mid-operation: contents must come back as zero.
        do_reset();
        walk_and_count();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)));
            run_cycle("post", 1'b0, 32'd0, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
